// File: rtl/operand_entry.sv
// Switch/button entry stage for the 3-bit calculator: debounces NEXT/CLR and
// steps through capturing A, B and the operation code K.
module operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic [1:0] op_sw,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [1:0] K,
  output logic       valid,
  output logic [1:0] stage,
  output logic       div_zero
);

  localparam int unsigned CntW = 20;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StA = 2'd0, StB = 2'd1, StOp = 2'd2, StShow = 2'd3} state_e;

  // Index 0 is NEXT, index 1 is CLR; both buttons share identical conditioning.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      level_q, level_d;
  logic [1:0]      level_prev_q;
  logic [1:0]      pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];

  assign btn_raw = {btn_clr, btn_next};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    pulse_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pulse_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pulse_q      <= pulse_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  state_e     state_q, state_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [1:0] k_q, k_d;
  logic       valid_q, valid_d;
  logic       div_zero_q, div_zero_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    valid_d    = valid_q;
    div_zero_d = div_zero_q;
    // Clear has priority; a coincident next pulse is dropped.
    if (pulse_q[1]) begin
      state_d    = StA;
      a_d        = '0;
      b_d        = '0;
      k_d        = '0;
      valid_d    = 1'b0;
      div_zero_d = 1'b0;
    end else if (pulse_q[0]) begin
      case (state_q)
        StA: begin
          a_d     = sw;
          state_d = StB;
        end
        StB: begin
          b_d     = sw;
          state_d = StOp;
        end
        StOp: begin
          k_d        = op_sw;
          valid_d    = 1'b1;
          div_zero_d = (op_sw == 2'b11) && (b_q == 3'd0);
          state_d    = StShow;
        end
        StShow: begin
          valid_d    = 1'b0;
          div_zero_d = 1'b0;
          state_d    = StA;
        end
        default: state_d = StA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StA;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      valid_q    <= valid_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign K        = k_q;
  assign valid    = valid_q;
  assign stage    = state_q;
  assign div_zero = div_zero_q;

endmodule
